// File: rtl/reg_file_scoreboard_if.sv
// Bus between the decode stage and the register file / scoreboard.
// Valid semantics: emite and escreve are single-cycle valids with no ready
// back-pressure. Each one high at a rising edge is consumed at that edge.
// The consumer holds emite low while stall is high, so the block never
// needs to refuse an issue.
interface reg_file_scoreboard_if #(
  parameter int DATA_W = 32
);
  logic              emite;
  logic [4:0]        emite_dest;
  logic              escreve;
  logic [4:0]        escreve_end;
  logic [DATA_W-1:0] escreve_dado;
  logic [4:0]        le_end1;
  logic [4:0]        le_end2;
  logic [DATA_W-1:0] le_dado1;
  logic [DATA_W-1:0] le_dado2;
  logic              ocupado1;
  logic              ocupado2;
  logic              stall;
  logic [31:0]       habilita_escrita;

  // Pipeline side: drives issue, writeback and read addresses.
  modport master (
    output emite, emite_dest, escreve, escreve_end, escreve_dado,
           le_end1, le_end2,
    input  le_dado1, le_dado2, ocupado1, ocupado2, stall, habilita_escrita
  );

  // Register file side.
  modport slave (
    input  emite, emite_dest, escreve, escreve_end, escreve_dado,
           le_end1, le_end2,
    output le_dado1, le_dado2, ocupado1, ocupado2, stall, habilita_escrita
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// MIPS register file (31 stored registers, $zero hardwired) with two
// combinational read ports, same-cycle write bypass, a one-hot write decode
// kept for trace, and a per-register pending-write scoreboard.
module reg_file_scoreboard #(
  parameter int DATA_W = 32
) (
  input logic                  clock,
  input logic                  reset_n,
  reg_file_scoreboard_if.slave bus
);

  logic [DATA_W-1:0] regs_q [1:31];
  logic [DATA_W-1:0] regs_d [1:31];
  logic [31:0]       busy_q;
  logic [31:0]       busy_d;
  logic [31:0]       hab_q;
  logic [31:0]       wen;
  logic [31:0]       set_vec;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              oc1;
  logic              oc2;

  // One-hot decode of the writeback and the issue; address 0 never decodes.
  always_comb begin
    wen     = '0;
    set_vec = '0;
    for (int i = 1; i < 32; i++) begin
      wen[i]     = bus.escreve && (bus.escreve_end == 5'(i));
      set_vec[i] = bus.emite && (bus.emite_dest == 5'(i));
    end
  end

  // Next state: storage takes the writeback, scoreboard clears on write and
  // sets on issue, with the set taking priority (the newer issue is pending).
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < 32; i++) begin
      if (wen[i]) regs_d[i] = bus.escreve_dado;
    end
    busy_d    = (busy_q & ~wen) | set_vec;
    busy_d[0] = 1'b0;
  end

  // State registers; reset discards all data and pending writes at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      busy_q <= '0;
      hab_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      hab_q  <= wen;
    end
  end

  // Read port 1: $zero, then bypass from the writeback, then storage.
  always_comb begin
    rd1 = '0;
    oc1 = 1'b0;
    if (bus.le_end1 != 5'd0) begin
      if (bus.escreve && (bus.escreve_end == bus.le_end1)) begin
        rd1 = bus.escreve_dado;
      end else begin
        rd1 = regs_q[bus.le_end1];
        oc1 = busy_q[bus.le_end1];
      end
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd2 = '0;
    oc2 = 1'b0;
    if (bus.le_end2 != 5'd0) begin
      if (bus.escreve && (bus.escreve_end == bus.le_end2)) begin
        rd2 = bus.escreve_dado;
      end else begin
        rd2 = regs_q[bus.le_end2];
        oc2 = busy_q[bus.le_end2];
      end
    end
  end

  assign bus.le_dado1         = rd1;
  assign bus.le_dado2         = rd2;
  assign bus.ocupado1         = oc1;
  assign bus.ocupado2         = oc2;
  assign bus.stall            = oc1 | oc2;
  assign bus.habilita_escrita = hab_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: the driver sets inputs just after
// each rising edge and queues the hand-computed responses; the monitor pops
// and compares them on the following falling edge.
module tb_reg_file_scoreboard;
  localparam int W = 32;

  localparam int K_DADO1 = 0;
  localparam int K_DADO2 = 1;
  localparam int K_OC1   = 2;
  localparam int K_OC2   = 3;
  localparam int K_STALL = 4;
  localparam int K_HAB   = 5;

  logic clock;
  logic reset_n;

  reg_file_scoreboard_if #(.DATA_W(W)) bus ();

  reg_file_scoreboard #(.DATA_W(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard storage
  logic [W-1:0] exp_q[$];
  int           kind_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic expect_val(input int kind, input logic [W-1:0] v, input string name);
    exp_q.push_back(v);
    kind_q.push_back(kind);
    name_q.push_back(name);
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      int           k;
      string        n;
      e = exp_q.pop_front();
      k = kind_q.pop_front();
      n = name_q.pop_front();
      case (k)
        K_DADO1: a = bus.le_dado1;
        K_DADO2: a = bus.le_dado2;
        K_OC1:   a = W'(bus.ocupado1);
        K_OC2:   a = W'(bus.ocupado2);
        K_STALL: a = W'(bus.stall);
        default: a = bus.habilita_escrita;
      endcase
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic em, input logic [4:0] ed,
                       input logic es, input logic [4:0] ee, input logic [W-1:0] dd,
                       input logic [4:0] l1, input logic [4:0] l2);
    bus.emite        = em;
    bus.emite_dest   = ed;
    bus.escreve      = es;
    bus.escreve_end  = ee;
    bus.escreve_dado = dd;
    bus.le_end1      = l1;
    bus.le_end2      = l2;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, '0, 0, 0);

    // Reset state
    step();
    drive(0, 0, 0, 0, '0, 1, 2);
    expect_val(K_DADO1, 0, "rst_dado1");
    expect_val(K_OC1, 0, "rst_oc1");
    expect_val(K_STALL, 0, "rst_stall");
    expect_val(K_HAB, 0, "rst_hab");
    reset_n = 1'b1;

    // Write 5 and 9 (9 also issued so it is busy), then reset mid-cycle
    step();
    drive(0, 0, 1, 5, 32'h0000_0055, 0, 0);
    step();
    drive(1, 9, 1, 9, 32'h0000_0099, 0, 0);
    step();
    drive(0, 0, 0, 0, '0, 5, 9);
    expect_val(K_DADO1, 32'h55, "pre_rst_r5");
    expect_val(K_DADO2, 32'h99, "pre_rst_r9");
    expect_val(K_OC2, 1, "pre_rst_busy9");
    expect_val(K_STALL, 1, "pre_rst_stall");
    expect_val(K_HAB, 32'h0000_0200, "pre_rst_hab9");
    step();
    #2 reset_n = 1'b0;
    expect_val(K_DADO1, 0, "midrst_r5");
    expect_val(K_DADO2, 0, "midrst_r9");
    expect_val(K_STALL, 0, "midrst_stall");
    expect_val(K_HAB, 0, "midrst_hab");
    step();
    reset_n = 1'b1;
    step();
    expect_val(K_OC2, 0, "post_rst_busy9");
    expect_val(K_DADO2, 0, "post_rst_r9");

    // $zero: write and issue to 0 are dropped
    step();
    drive(1, 0, 1, 0, 32'hDEAD_BEEF, 0, 0);
    expect_val(K_DADO1, 0, "zero_bypass");
    expect_val(K_OC1, 0, "zero_oc");
    step();
    drive(0, 0, 0, 0, '0, 0, 0);
    expect_val(K_DADO1, 0, "zero_stored");
    expect_val(K_OC1, 0, "zero_busy");
    expect_val(K_HAB, 0, "zero_hab");

    // Write/read with bypass on reg 7
    step();
    drive(0, 0, 1, 7, 32'h1234_5678, 7, 0);
    expect_val(K_DADO1, 32'h1234_5678, "r7_bypass");
    expect_val(K_OC1, 0, "r7_oc");
    step();
    drive(0, 0, 0, 0, '0, 7, 0);
    expect_val(K_DADO1, 32'h1234_5678, "r7_stored");
    expect_val(K_HAB, 32'h0000_0080, "r7_hab");
    step();
    expect_val(K_HAB, 0, "idle_hab");

    // Hazard on reg 3
    step();
    drive(1, 3, 0, 0, '0, 0, 3);
    expect_val(K_OC2, 0, "r3_issue_cycle");
    step();
    drive(0, 0, 0, 0, '0, 0, 3);
    expect_val(K_OC2, 1, "r3_busy");
    expect_val(K_STALL, 1, "r3_stall");
    step();
    drive(0, 0, 1, 3, 32'h0000_00A5, 0, 3);
    expect_val(K_OC2, 0, "r3_wb_oc");
    expect_val(K_DADO2, 32'hA5, "r3_wb_dado");
    expect_val(K_STALL, 0, "r3_wb_stall");
    step();
    drive(0, 0, 0, 0, '0, 0, 3);
    expect_val(K_OC2, 0, "r3_cleared");
    expect_val(K_DADO2, 32'hA5, "r3_stored");
    expect_val(K_HAB, 32'h0000_0008, "r3_hab");

    // Simultaneous set and clear on reg 4: set wins
    step();
    drive(1, 4, 0, 0, '0, 0, 0);
    step();
    drive(1, 4, 1, 4, 32'h0000_0011, 4, 0);
    expect_val(K_DADO1, 32'h11, "r4_bypass");
    expect_val(K_OC1, 0, "r4_bypass_oc");
    step();
    drive(0, 0, 0, 0, '0, 4, 0);
    expect_val(K_DADO1, 32'h11, "r4_stored");
    expect_val(K_OC1, 1, "r4_still_busy");
    expect_val(K_STALL, 1, "r4_stall");
    step();
    drive(0, 0, 1, 4, 32'h0000_0022, 4, 0);
    step();
    drive(0, 0, 0, 0, '0, 4, 0);
    expect_val(K_OC1, 0, "r4_cleared");
    expect_val(K_DADO1, 32'h22, "r4_second");

    // Dual port on reg 31
    step();
    drive(0, 0, 1, 31, 32'hFFFF_FFFF, 0, 0);
    step();
    drive(0, 0, 0, 0, '0, 31, 31);
    expect_val(K_DADO1, 32'hFFFF_FFFF, "r31_p1");
    expect_val(K_DADO2, 32'hFFFF_FFFF, "r31_p2");
    expect_val(K_OC1, 0, "r31_oc1");
    expect_val(K_OC2, 0, "r31_oc2");
    expect_val(K_HAB, 32'h8000_0000, "r31_hab");
    step();
    drive(1, 31, 0, 0, '0, 31, 31);
    step();
    drive(0, 0, 0, 0, '0, 31, 31);
    expect_val(K_OC1, 1, "r31_busy1");
    expect_val(K_OC2, 1, "r31_busy2");

    // Drain the scoreboard with a bounded wait
    begin
      int budget;
      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clock);
        #1;
        budget--;
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Write-side counterpart to the 5-bit, 4-input destination-register select mux. It takes the selected 5-bit destination address and decodes it into 32 one-hot write enables. It holds the 32×DATA_W MIPS register file with two read ports, same-cycle write bypass and `$zero` hardwired. It also keeps a per-register pending-write scoreboard so the decode stage can detect read-after-write hazards and stall.

## Interface
- DATA_W, 32, register data width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- emite  in  1  issue valid: an instruction with a destination register leaves decode this cycle
- emite_dest  in  5  destination address of the issued instruction (output of the destination select mux)
- escreve  in  1  writeback valid
- escreve_end  in  5  writeback destination address
- escreve_dado  in  DATA_W  writeback data
- le_end1, le_end2  in  5  source addresses, read ports 1/2
- le_dado1, le_dado2  out  DATA_W  read data, ports 1/2
- ocupado1, ocupado2  out  1  source has a pending write not yet available
- stall  out  1  ocupado1 | ocupado2
- habilita_escrita  out  32  registered one-hot decode of the last committed write (trace/debug)

## Operation
- Storage: regs[1..31], DATA_W each. regs[0] is not stored and always reads 0.
- Write decode: wen[i] = escreve & (escreve_end == i) for i in 1..31. wen[0] is always 0.
- On each clock edge, regs[i] <= escreve_dado where wen[i]=1. A write to address 0 is dropped silently.
- habilita_escrita <= wen every edge. A cycle without a write therefore loads 0.
- Scoreboard: busy[1..31], one bit each. busy[0] is constant 0.
  - Set on the edge where emite=1 and emite_dest=i, i≠0.
  - Cleared on the edge where wen[i]=1.
  - If set and clear target the same i on the same edge, set wins. The newer issue is still pending.
  - Issuing to an already-busy register leaves it busy. The pipeline is in-order, so one bit per register suffices.
- Read port k, combinational:
  - If le_endk == 0: le_dadok = 0 and ocupadok = 0.
  - Else if escreve & (escreve_end == le_endk): le_dadok = escreve_dado (bypass) and ocupadok = 0.
  - Else: le_dadok = regs[le_endk] and ocupadok = busy[le_endk].
- stall = ocupado1 | ocupado2. The block never stalls itself; the consumer holds emite low while stall=1.
- Both read ports may address the same register and return identical data and busy flags.

## Timing
- Reset (reset_n=0, asynchronous): all regs=0, all busy=0, habilita_escrita=0. Consequently le_dado1/2=0, ocupado1/2=0, stall=0. Reset takes effect immediately, mid-operation included; pending state is discarded.
- Release: the first active edge is the first clock rise with reset_n=1.
- Read latency: 0 cycles (combinational from le_end, escreve, escreve_end, escreve_dado and stored state).
- Write latency: data is visible the same cycle through the bypass, and from storage on the cycle after the edge.
- Busy latency: ocupado rises the cycle after the emite edge. It falls combinationally in the writeback cycle via the bypass, and from storage after that edge.
- habilita_escrita: 1 cycle after the write.

## Test plan
- Reset: write regs 5 and 9, pulse reset_n low mid-cycle -> immediately le_dado=0 for 5 and 9, stall=0, habilita_escrita=0.
- $zero: escreve=1, escreve_end=0, dado=0xDEADBEEF; emite_dest=0 -> le_end1=0 reads 0, ocupado1=0, habilita_escrita=0 after the edge.
- Write/read and bypass: escreve to reg 7 with 0x12345678 while le_end1=7 -> le_dado1=0x12345678 in the same cycle. After the edge, with escreve=0, still 0x12345678. habilita_escrita=0x00000080.
- Hazard: emite, dest=3. Next cycle le_end2=3 -> ocupado2=1, stall=1. Writeback to 3 with 0xA5 -> ocupado2=0 and le_dado2=0xA5 in that cycle; busy[3] clear afterwards.
- Simultaneous set/clear: busy[4]=1; same edge emite dest=4 and escreve to 4 with 0x11 -> after the edge regs[4]=0x11 and ocupado for 4 = 1.
- Dual port: le_end1=le_end2=31 after writing 0xFFFFFFFF -> both ports return 0xFFFFFFFF with equal ocupado.
